instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Instruction source for the multi-cycle processor; drives the processor's 16-bit `iin` word and `resetn`-domain sequencing.
- Holds a small loadable program memory and a program counter. Presents one instruction word, then holds it stable until the processor signals completion (its control-unit `clear` pulse, wired to `done`).
- Advances to the next word on completion; stops on a HALT word or at the end of memory.

Parameters:
- `ADDR_W`, 5, program memory address width; depth = 2^ADDR_W words.
- `WIDTH`, 16, instruction word width; must match processor `iin`.
- `HALT_WORD`, 16'hFFFF, reserved encoding that stops sequencing and is never issued.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `load_en`  in  1  program write strobe.
- `load_addr`  in  ADDR_W  program write address.
- `load_data`  in  WIDTH  program write data.
- `start`  in  1  single-cycle pulse; begins execution at address 0.
- `done`  in  1  processor instruction-complete pulse.
- `step`  in  1  single-step advance pulse; used only with the optional feature.
- `iin`  out  WIDTH  instruction word to the processor.
- `iin_valid`  out  1  `iin` holds a live instruction.
- `pc`  out  ADDR_W  address of the current or next word.
- `running`  out  1  high in FETCH/ISSUE/PAUSE.
- `halted`  out  1  high in HALT.

Behaviour:
- Reset (async, `resetn` = 0):
  - state = IDLE; `pc` = 0; `iin` = 0; `iin_valid` = 0; `running` = 0; `halted` = 0.
  - Memory contents are not cleared.
  - Reset asserted mid-operation aborts immediately; no further word is issued.
- States: IDLE, FETCH, ISSUE, HALT (plus PAUSE with the optional feature).
- IDLE:
  - `load_en` = 1 writes `mem[load_addr] <= load_data`.
  - `start` moves to FETCH with `pc <= 0`.
  - `done` is ignored.
- FETCH (exactly 1 cycle, synchronous memory read):
  - If `mem[pc] == HALT_WORD`: go to HALT; `iin_valid` stays 0; `iin` is unchanged.
  - Otherwise: `iin <= mem[pc]`, `iin_valid <= 1`, go to ISSUE.
- ISSUE:
  - `iin` is held stable and `iin_valid` = 1 until `done`.
  - On `done`: `iin_valid <= 0`.
    - If `pc == 2^ADDR_W - 1`: go to HALT, `pc` unchanged (no wrap).
    - Otherwise: `pc <= pc + 1`, go to FETCH.
  - `start` and `load_en` are ignored.
  - `done` and `start` in the same cycle: `done` wins and `start` is dropped.
- HALT:
  - `halted` = 1; `iin` holds the last issued word; `iin_valid` = 0.
  - `load_en` writes are accepted, as in IDLE.
  - `start` clears `halted` and moves to FETCH with `pc <= 0`.
  - `start` and `load_en` in the same cycle: the write completes before the FETCH read.
- Timing:
  - Latency from `start` to `iin_valid` = 2 cycles.
  - From `done` to the next `iin_valid` = 2 cycles.
  - One instruction is in flight at most.
- Loads while `running` = 1 are dropped silently; memory is unchanged.
- `done` is a level sampled once per cycle. A `done` held high for N cycles in ISSUE counts once; re-entry into ISSUE requires a FETCH cycle first.
- `pc` arithmetic is unsigned, ADDR_W bits wide. The end-of-memory test is applied before the increment, so overflow is impossible.

Optional Feature:
- Macro: `INSTR_SEQ_SINGLE_STEP_EN`.
- Defined:
  - On `done` in ISSUE (not end of memory), `pc` increments and the FSM enters PAUSE instead of FETCH.
  - PAUSE holds `iin_valid` = 0 and `running` = 1.
  - A `step` pulse moves PAUSE to FETCH. `start` in PAUSE is ignored.
- Undefined:
  - PAUSE is not built; `step` is ignored.
  - Behaviour is exactly as described above.

Test Plan:
- Load `mem[0..2]` = 16'h1040, 16'h2080, 16'hFFFF; pulse `start` → `iin` = 16'h1040 with `iin_valid` 2 cycles later.
  - Hold 5 cycles, `done` → 2 cycles later `iin` = 16'h2080, `pc` = 1.
  - `done` → HALT with `halted` = 1 and `pc` = 2; `iin` stays 16'h2080.
- Fill all 32 words with 16'h0001; `start`; 32 `done` pulses → exactly 32 issues, then HALT with `pc` = 31 and no wrap to 0.
- In ISSUE, assert `load_en` to address 0 with 16'hABCD → `mem[0]` unchanged. Same cycle, assert `done` with `start` → normal advance; `start` ignored.
- Hold `done` high for 4 cycles in ISSUE → `pc` advances by 1 only.
- Assert `resetn` = 0 during ISSUE at `pc` = 3 → `iin` = 0, `iin_valid` = 0, `pc` = 0 immediately (async). After release, state is IDLE; previously loaded memory re-runs on `start`.
- With `INSTR_SEQ_SINGLE_STEP_EN`: `done` at `pc` = 0 → PAUSE with `pc` = 1 and `iin_valid` = 0 for 10 cycles; `step` → `iin_valid` 2 cycles later with `mem[1]`.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction sequencer: loadable program memory that issues one word at a time and waits for done.
// Optional single-step PAUSE state is built when INSTR_SEQ_SINGLE_STEP_EN is defined.
module instr_sequencer #(
    parameter int                 ADDR_W    = 5,
    parameter int                 WIDTH     = 16,
    parameter logic [WIDTH-1:0]   HALT_WORD = 16'hFFFF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              start,
    input  logic              done,
    input  logic              step,
    output logic [WIDTH-1:0]  iin,
    output logic              iin_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              running,
    output logic              halted
);

    localparam int                DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PC_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PC_ZERO = {ADDR_W{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
`ifdef INSTR_SEQ_SINGLE_STEP_EN
        S_PAUSE = 3'd4,
`endif
        S_HALT  = 3'd3
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] pc_r;
    logic [WIDTH-1:0]  iin_r;
    logic              iin_valid_r;
    logic              running_r;
    logic              halted_r;
    logic              done_block_r;
    logic [WIDTH-1:0]  mem_r [DEPTH];

    logic              wr_en_s;
    logic              done_acc_s;
    logic [WIDTH-1:0]  rd_word_s;

`ifdef INSTR_SEQ_SINGLE_STEP_EN
`else
    logic              unused_step_s;
    assign unused_step_s = step;
`endif

    // Write permission, edge-qualified done and the memory read port.
    always_comb begin
        wr_en_s    = load_en && ((state_r == S_IDLE) || (state_r == S_HALT));
        done_acc_s = done && !done_block_r;
        rd_word_s  = mem_r[pc_r];
    end

    // Program memory write port; contents survive reset.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem_r[load_addr] <= load_data;
        end
    end

    // Sequencing FSM with registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r      <= S_IDLE;
            pc_r         <= PC_ZERO;
            iin_r        <= {WIDTH{1'b0}};
            iin_valid_r  <= 1'b0;
            running_r    <= 1'b0;
            halted_r     <= 1'b0;
            done_block_r <= 1'b0;
        end else begin
            // A done level is honoured once; it must drop before another is accepted.
            if (!done) begin
                done_block_r <= 1'b0;
            end else if ((state_r == S_ISSUE) && done_acc_s) begin
                done_block_r <= 1'b1;
            end else begin
                done_block_r <= done_block_r;
            end

            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_r   <= S_FETCH;
                        pc_r      <= PC_ZERO;
                        running_r <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (rd_word_s == HALT_WORD) begin
                        state_r   <= S_HALT;
                        running_r <= 1'b0;
                        halted_r  <= 1'b1;
                    end else begin
                        iin_r       <= rd_word_s;
                        iin_valid_r <= 1'b1;
                        state_r     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (done_acc_s) begin
                        iin_valid_r <= 1'b0;
                        if (pc_r == PC_LAST) begin
                            state_r   <= S_HALT;
                            running_r <= 1'b0;
                            halted_r  <= 1'b1;
                        end else begin
                            pc_r <= pc_r + PC_ONE;
`ifdef INSTR_SEQ_SINGLE_STEP_EN
                            state_r <= S_PAUSE;
`else
                            state_r <= S_FETCH;
`endif
                        end
                    end
                end
`ifdef INSTR_SEQ_SINGLE_STEP_EN
                S_PAUSE: begin
                    if (step) begin
                        state_r <= S_FETCH;
                    end
                end
`endif
                S_HALT: begin
                    if (start) begin
                        state_r   <= S_FETCH;
                        pc_r      <= PC_ZERO;
                        running_r <= 1'b1;
                        halted_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    iin_valid_r <= 1'b0;
                    running_r   <= 1'b0;
                    halted_r    <= 1'b0;
                end
            endcase
        end
    end

    assign iin       = iin_r;
    assign iin_valid = iin_valid_r;
    assign pc        = pc_r;
    assign running   = running_r;
    assign halted    = halted_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer.
module tb_instr_sequencer;

    logic        clock;
    logic        resetn;
    logic        load_en;
    logic [4:0]  load_addr;
    logic [15:0] load_data;
    logic        start;
    logic        done;
    logic        step;
    logic [15:0] iin;
    logic        iin_valid;
    logic [4:0]  pc;
    logic        running;
    logic        halted;

    int checks;
    int errors;
    int issues;

    instr_sequencer dut (
        .clock     (clock),
        .resetn    (resetn),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .done      (done),
        .step      (step),
        .iin       (iin),
        .iin_valid (iin_valid),
        .pc        (pc),
        .running   (running),
        .halted    (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic load(input logic [4:0] a, input logic [15:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        cyc();
        load_en   = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        issues    = 0;
        resetn    = 1'b0;
        load_en   = 1'b0;
        load_addr = 5'd0;
        load_data = 16'h0000;
        start     = 1'b0;
        done      = 1'b0;
        step      = 1'b0;
        cyc();
        cyc();
        chk("rst_iin", {16'h0, iin}, 32'h0);
        chk("rst_valid", {31'h0, iin_valid}, 32'h0);
        chk("rst_pc", {27'h0, pc}, 32'h0);
        chk("rst_running", {31'h0, running}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        resetn = 1'b1;
        cyc();

        // Short program ending in HALT_WORD
        load(5'd0, 16'h1040);
        load(5'd1, 16'h2080);
        load(5'd2, 16'hFFFF);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("fetch_valid", {31'h0, iin_valid}, 32'h0);
        chk("fetch_running", {31'h0, running}, 32'h1);
        cyc();
        chk("issue0_iin", {16'h0, iin}, 32'h1040);
        chk("issue0_valid", {31'h0, iin_valid}, 32'h1);
        repeat (5) cyc();
        chk("hold_iin", {16'h0, iin}, 32'h1040);
        chk("hold_valid", {31'h0, iin_valid}, 32'h1);
        done = 1'b1;
        cyc();
        done = 1'b0;
        chk("adv_gap_valid", {31'h0, iin_valid}, 32'h0);
        cyc();
        chk("issue1_iin", {16'h0, iin}, 32'h2080);
        chk("issue1_pc", {27'h0, pc}, 32'h1);
        chk("issue1_valid", {31'h0, iin_valid}, 32'h1);
        done = 1'b1;
        cyc();
        done = 1'b0;
        cyc();
        chk("halt_halted", {31'h0, halted}, 32'h1);
        chk("halt_pc", {27'h0, pc}, 32'h2);
        chk("halt_iin", {16'h0, iin}, 32'h2080);
        chk("halt_valid", {31'h0, iin_valid}, 32'h0);
        chk("halt_running", {31'h0, running}, 32'h0);

        // Full memory run: 32 issues then stop at the last address
        for (int i = 0; i < 32; i++) load(i[4:0], 16'h0001);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("restart_halted", {31'h0, halted}, 32'h0);
        for (int k = 0; k < 32; k++) begin
            cyc();
            if (iin_valid === 1'b1 && pc === k[4:0]) issues++;
            done = 1'b1;
            cyc();
            done = 1'b0;
        end
        chk("full_issues", issues, 32);
        chk("full_halted", {31'h0, halted}, 32'h1);
        chk("full_pc", {27'h0, pc}, 32'h1F);
        cyc();
        chk("nowrap_pc", {27'h0, pc}, 32'h1F);
        chk("nowrap_valid", {31'h0, iin_valid}, 32'h0);

        // Load dropped while running; done beats start
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        chk("run_iin", {16'h0, iin}, 32'h0001);
        load(5'd0, 16'hABCD);
        chk("dropload_iin", {16'h0, iin}, 32'h0001);
        chk("dropload_pc", {27'h0, pc}, 32'h0);
        done  = 1'b1;
        start = 1'b1;
        cyc();
        done  = 1'b0;
        start = 1'b0;
`ifdef INSTR_SEQ_SINGLE_STEP_EN
        chk("donestart_pc", {27'h0, pc}, 32'h1);
        repeat (10) cyc();
        chk("pause_pc", {27'h0, pc}, 32'h1);
        chk("pause_valid", {31'h0, iin_valid}, 32'h0);
        chk("pause_running", {31'h0, running}, 32'h1);
        step = 1'b1;
        cyc();
        step = 1'b0;
        chk("step_gap_valid", {31'h0, iin_valid}, 32'h0);
        cyc();
        chk("step_valid", {31'h0, iin_valid}, 32'h1);
        chk("step_iin", {16'h0, iin}, 32'h0001);
        chk("step_pc", {27'h0, pc}, 32'h1);
`else
        step = 1'b1;
        chk("donestart_pc", {27'h0, pc}, 32'h1);
        chk("donestart_valid", {31'h0, iin_valid}, 32'h0);
        cyc();
        step = 1'b0;
        chk("donestart_iin", {16'h0, iin}, 32'h0001);
        chk("donestart_valid2", {31'h0, iin_valid}, 32'h1);
        chk("donestart_pc2", {27'h0, pc}, 32'h1);

        // A held done level counts once
        done = 1'b1;
        repeat (4) cyc();
        done = 1'b0;
        chk("held_pc", {27'h0, pc}, 32'h2);
        chk("held_valid", {31'h0, iin_valid}, 32'h1);
        cyc();
        chk("held_pc2", {27'h0, pc}, 32'h2);
        done = 1'b1;
        cyc();
        done = 1'b0;
        cyc();
        chk("pc3_pc", {27'h0, pc}, 32'h3);
        chk("pc3_valid", {31'h0, iin_valid}, 32'h1);

        // Asynchronous reset mid-cycle in ISSUE
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_iin", {16'h0, iin}, 32'h0);
        chk("arst_valid", {31'h0, iin_valid}, 32'h0);
        chk("arst_pc", {27'h0, pc}, 32'h0);
        chk("arst_running", {31'h0, running}, 32'h0);
        cyc();
        resetn = 1'b1;
        cyc();
        chk("post_rst_running", {31'h0, running}, 32'h0);
        chk("post_rst_halted", {31'h0, halted}, 32'h0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        chk("rerun_iin", {16'h0, iin}, 32'h0001);
        chk("rerun_valid", {31'h0, iin_valid}, 32'h1);
        chk("rerun_pc", {27'h0, pc}, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
